textmem_arb: RTL and testbench
==============================

TEXTMEM_ARB -- requirements
Module: textmem_arb

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 255: memory cycles to wait for mem_ack_i before a grant is aborted.
REQ-002 The block SHALL have parameter STARVE, default 64: CPU wait cycles after which the CPU wins arbitration.
REQ-003 clk_i  in  1  system clock.
REQ-004 rst_i  in  1  reset, asynchronous, active-high.
REQ-005 vid_cyc_i  in  1  text-refresh fetch request, read only, held until vid_ack_o.
REQ-006 vid_adr_i  in  32  text-refresh fetch address.
REQ-007 vid_dat_o  out  32  text-refresh read data, valid with vid_ack_o.
REQ-008 vid_ack_o  out  1  text-refresh transfer done.
REQ-009 cpu_cyc_i  in  1  CPU request, held until cpu_ack_o or cpu_err_o.
REQ-010 cpu_we_i  in  1  CPU write enable.
REQ-011 cpu_sel_i  in  4  CPU byte selects.
REQ-012 cpu_adr_i  in  32  CPU address.
REQ-013 cpu_dat_i  in  32  CPU write data.
REQ-014 cpu_dat_o  out  32  CPU read data, valid with cpu_ack_o.
REQ-015 cpu_ack_o  out  1  CPU transfer done.
REQ-016 cpu_err_o  out  1  CPU transfer timed out.
REQ-017 mem_cyc_o, mem_we_o (1), mem_sel_o (4), mem_adr_o (32), mem_dat_o (32)  out  shared text-memory request.
REQ-018 mem_dat_i (32), mem_ack_i (1)  in  shared text-memory response.

Function
REQ-019 The FSM SHALL have states S_IDLE, S_VID and S_CPU.
REQ-020 In S_IDLE, the FSM SHALL go to S_VID if vid_cyc_i is high and starved is low; otherwise to S_CPU if cpu_cyc_i is high; otherwise it SHALL stay in S_IDLE.
REQ-021 starved SHALL be set when the CPU wait counter reaches STARVE.
REQ-022 If starved is high and cpu_cyc_i is high, the FSM SHALL go from S_IDLE to S_CPU even when vid_cyc_i is high.
REQ-023 The CPU wait counter SHALL increment each cycle that cpu_cyc_i is high and the state is not S_CPU, saturate at STARVE, and clear on entry to S_CPU or when cpu_cyc_i is low.
REQ-024 In S_VID: mem_cyc_o=vid_cyc_i, mem_we_o=0, mem_sel_o=4'hF, mem_adr_o=vid_adr_i, vid_ack_o=mem_ack_i, vid_dat_o=mem_dat_i (combinational, zero added latency).
REQ-025 In S_CPU: mem_cyc_o=cpu_cyc_i, mem_we_o/sel/adr/dat from cpu_*, cpu_ack_o=mem_ack_i, cpu_dat_o=mem_dat_i.
REQ-026 Outside its granted state, every requester output and every mem_* output SHALL be 0.
REQ-027 On mem_ack_i in S_VID or S_CPU, the FSM SHALL return to S_IDLE; this gives exactly one dead cycle between grants, so grant latency is 1 cycle from request when idle.
REQ-028 If the granted requester drops cyc before the ack, mem_cyc_o SHALL fall in the same cycle and the FSM SHALL return to S_IDLE next cycle; any late mem_ack_i in S_IDLE SHALL be ignored.
REQ-029 An 8-bit+ timeout counter SHALL clear on every grant entry and increment each granted cycle without an ack.
REQ-030 When the timeout counter reaches TIMEOUT: in S_CPU, cpu_err_o SHALL pulse for 1 cycle with cpu_ack_o=0; in S_VID, vid_ack_o SHALL pulse with vid_dat_o=32'h0, so the refresh never hangs; then the FSM SHALL go to S_IDLE.
REQ-031 An ack in the same cycle as a timeout SHALL win: a normal ack with mem_dat_i and no error.
REQ-032 Reads and writes SHALL carry no address translation; mem_adr_o SHALL equal the requester's address bit-for-bit.

Reset
REQ-033 On rst_i high, the state SHALL be S_IDLE, both counters 0 and starved 0, so all outputs are 0 asynchronously.
REQ-034 Reset mid-transfer SHALL abandon the transfer and emit no ack or err; after release, arbitration SHALL restart from S_IDLE.

Structure
REQ-035 Package textmem_pkg SHALL hold arb_state_t (S_IDLE, S_VID, S_CPU) and the default TIMEOUT/STARVE constants.
REQ-036 The block SHALL be flat (no sub-module): one state register, two counters, and the combinational output mux.

Verification
REQ-037 Idle, then cpu read at 0x40 with mem ack after 3 cycles -> mem_cyc_o rises at cycle 1, cpu_ack_o at cycle 4, cpu_dat_o=mem_dat_i.
REQ-038 vid_cyc_i and cpu_cyc_i rise together -> S_VID granted first; S_CPU follows one dead cycle after vid_ack_o.
REQ-039 Video requests continuously with gapless re-requests, CPU waiting -> after 64 wait cycles, the CPU is granted at the next S_IDLE.
REQ-040 CPU write with no mem ack, TIMEOUT=255 -> cpu_err_o is a 1-cycle pulse 255 cycles after grant, and the FSM is back in S_IDLE.
REQ-041 rst_i asserted during S_VID with an ack pending -> all outputs 0 immediately, no vid_ack_o; a new request after release gets a 1-cycle grant.

Source files
------------

// File: rtl/textmem_pkg.sv
// Shared types and defaults for the text-memory arbiter between video refresh and CPU.
package textmem_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_VID  = 2'd1,
        S_CPU  = 2'd2
    } arb_state_t;

    localparam int TIMEOUT_DEF = 255;
    localparam int STARVE_DEF  = 64;

    // Counter width able to hold max_val, never narrower than min_w.
    function automatic int cnt_width(input int max_val, input int min_w);
        return ($clog2(max_val + 1) > min_w) ? $clog2(max_val + 1) : min_w;
    endfunction

endpackage

// File: rtl/textmem_arb.sv
// Arbitrates the shared text memory between the video refresh fetch and the CPU,
// with CPU anti-starvation and a per-grant ack timeout.
module textmem_arb
    import textmem_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int STARVE  = STARVE_DEF
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        vid_cyc_i,
    input  logic [31:0] vid_adr_i,
    output logic [31:0] vid_dat_o,
    output logic        vid_ack_o,

    input  logic        cpu_cyc_i,
    input  logic        cpu_we_i,
    input  logic [3:0]  cpu_sel_i,
    input  logic [31:0] cpu_adr_i,
    input  logic [31:0] cpu_dat_i,
    output logic [31:0] cpu_dat_o,
    output logic        cpu_ack_o,
    output logic        cpu_err_o,

    output logic        mem_cyc_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_sel_o,
    output logic [31:0] mem_adr_o,
    output logic [31:0] mem_dat_o,
    input  logic [31:0] mem_dat_i,
    input  logic        mem_ack_i
);

    localparam int TW = cnt_width(TIMEOUT, 8);
    localparam int SW = cnt_width(STARVE, 1);

    arb_state_t      r_state;
    arb_state_t      w_next;
    logic [TW-1:0]   r_to_cnt;
    logic [SW-1:0]   r_wait_cnt;
    logic            w_starved;
    logic            w_timeout;
    logic            w_enter_cpu;

    assign w_starved   = (r_wait_cnt == SW'(STARVE));
    assign w_timeout   = (r_to_cnt == TW'(TIMEOUT));
    assign w_enter_cpu = (r_state != S_CPU) && (w_next == S_CPU);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (vid_cyc_i && !w_starved)
                    w_next = S_VID;
                else if (cpu_cyc_i)
                    w_next = S_CPU;
            end
            S_VID: begin
                if (!vid_cyc_i || mem_ack_i || w_timeout)
                    w_next = S_IDLE;
            end
            S_CPU: begin
                if (!cpu_cyc_i || mem_ack_i || w_timeout)
                    w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // Every grant is entered from S_IDLE, so clearing there covers grant entry.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            r_to_cnt <= '0;
        else if (r_state == S_IDLE)
            r_to_cnt <= '0;
        else if (!mem_ack_i && !w_timeout)
            r_to_cnt <= r_to_cnt + TW'(1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            r_wait_cnt <= '0;
        else if (!cpu_cyc_i || w_enter_cpu)
            r_wait_cnt <= '0;
        else if (r_state != S_CPU && !w_starved)
            r_wait_cnt <= r_wait_cnt + SW'(1);
    end

    always_comb begin
        mem_cyc_o = 1'b0;
        mem_we_o  = 1'b0;
        mem_sel_o = 4'h0;
        mem_adr_o = 32'h0;
        mem_dat_o = 32'h0;
        vid_ack_o = 1'b0;
        vid_dat_o = 32'h0;
        cpu_ack_o = 1'b0;
        cpu_err_o = 1'b0;
        cpu_dat_o = 32'h0;
        case (r_state)
            S_VID: begin
                mem_cyc_o = vid_cyc_i;
                mem_sel_o = 4'hF;
                mem_adr_o = vid_adr_i;
                // A timed-out refresh still completes, with blank data.
                vid_ack_o = mem_ack_i || w_timeout;
                vid_dat_o = (w_timeout && !mem_ack_i) ? 32'h0 : mem_dat_i;
            end
            S_CPU: begin
                mem_cyc_o = cpu_cyc_i;
                mem_we_o  = cpu_we_i;
                mem_sel_o = cpu_sel_i;
                mem_adr_o = cpu_adr_i;
                mem_dat_o = cpu_dat_i;
                cpu_ack_o = mem_ack_i;
                cpu_err_o = w_timeout && !mem_ack_i;
                cpu_dat_o = mem_dat_i;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_textmem_arb.sv
// Self-checking bench for textmem_arb: directed scenarios plus randomized traffic
// compared every cycle against a grant-level behavioural model.
module tb_textmem_arb;
    import textmem_pkg::*;

    localparam int TO_LIM = 255;
    localparam int ST_LIM = 64;

    logic        clk_i, rst_i;
    logic        vid_cyc_i;
    logic [31:0] vid_adr_i, vid_dat_o;
    logic        vid_ack_o;
    logic        cpu_cyc_i, cpu_we_i;
    logic [3:0]  cpu_sel_i;
    logic [31:0] cpu_adr_i, cpu_dat_i, cpu_dat_o;
    logic        cpu_ack_o, cpu_err_o;
    logic        mem_cyc_o, mem_we_o;
    logic [3:0]  mem_sel_o;
    logic [31:0] mem_adr_o, mem_dat_o, mem_dat_i;
    logic        mem_ack_i;

    textmem_arb #(.TIMEOUT(TO_LIM), .STARVE(ST_LIM)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .vid_cyc_i(vid_cyc_i), .vid_adr_i(vid_adr_i), .vid_dat_o(vid_dat_o), .vid_ack_o(vid_ack_o),
        .cpu_cyc_i(cpu_cyc_i), .cpu_we_i(cpu_we_i), .cpu_sel_i(cpu_sel_i), .cpu_adr_i(cpu_adr_i),
        .cpu_dat_i(cpu_dat_i), .cpu_dat_o(cpu_dat_o), .cpu_ack_o(cpu_ack_o), .cpu_err_o(cpu_err_o),
        .mem_cyc_o(mem_cyc_o), .mem_we_o(mem_we_o), .mem_sel_o(mem_sel_o), .mem_adr_o(mem_adr_o),
        .mem_dat_o(mem_dat_o), .mem_dat_i(mem_dat_i), .mem_ack_i(mem_ack_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // Model: who owns the memory (0 none, 1 video, 2 cpu), cycles spent in the grant, cpu wait cycles.
    int m_own = 0;
    int m_el = 0;
    int m_wait = 0;
    int e_own;

    logic        e_mem_cyc, e_mem_we, e_vid_ack, e_cpu_ack, e_cpu_err;
    logic [3:0]  e_mem_sel;
    logic [31:0] e_mem_adr, e_mem_dat, e_vid_dat, e_cpu_dat;
    logic        p_vid_done, p_cpu_done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic void model_eval();
        logic ack, tmo;
        e_mem_cyc = 0; e_mem_we = 0; e_mem_sel = 0; e_mem_adr = 0; e_mem_dat = 0;
        e_vid_ack = 0; e_vid_dat = 0; e_cpu_ack = 0; e_cpu_err = 0; e_cpu_dat = 0;
        e_own = m_own;
        ack = mem_ack_i;
        tmo = (m_el == TO_LIM);
        if (m_own == 1) begin
            e_mem_cyc = vid_cyc_i;
            e_mem_sel = 4'hF;
            e_mem_adr = vid_adr_i;
            e_vid_ack = ack | tmo;
            e_vid_dat = (tmo && !ack) ? 32'h0 : mem_dat_i;
        end else if (m_own == 2) begin
            e_mem_cyc = cpu_cyc_i;
            e_mem_we  = cpu_we_i;
            e_mem_sel = cpu_sel_i;
            e_mem_adr = cpu_adr_i;
            e_mem_dat = cpu_dat_i;
            e_cpu_ack = ack;
            e_cpu_err = tmo && !ack;
            e_cpu_dat = mem_dat_i;
        end
    endfunction

    task automatic compare_all();
        check("mem_cyc", 32'(mem_cyc_o), 32'(e_mem_cyc));
        check("mem_we",  32'(mem_we_o),  32'(e_mem_we));
        check("mem_sel", 32'(mem_sel_o), 32'(e_mem_sel));
        check("mem_adr", mem_adr_o, e_mem_adr);
        check("mem_dat", mem_dat_o, e_mem_dat);
        check("vid_ack", 32'(vid_ack_o), 32'(e_vid_ack));
        check("vid_dat", vid_dat_o, e_vid_dat);
        check("cpu_ack", 32'(cpu_ack_o), 32'(e_cpu_ack));
        check("cpu_err", 32'(cpu_err_o), 32'(e_cpu_err));
        check("cpu_dat", cpu_dat_o, e_cpu_dat);
    endtask

    function automatic void model_advance();
        int old;
        bit starved, done;
        if (rst_i) begin
            m_own = 0; m_el = 0; m_wait = 0;
            return;
        end
        old = m_own;
        starved = (m_wait >= ST_LIM);
        if (old == 0) begin
            if (vid_cyc_i && !starved) m_own = 1;
            else if (cpu_cyc_i) m_own = 2;
            m_el = 0;
        end else begin
            done = mem_ack_i || (m_el == TO_LIM) || (old == 1 ? !vid_cyc_i : !cpu_cyc_i);
            if (done) m_own = 0;
            else m_el++;
        end
        if (!cpu_cyc_i || (old != 2 && m_own == 2)) m_wait = 0;
        else if (old != 2) m_wait = (m_wait + 1 > ST_LIM) ? ST_LIM : m_wait + 1;
    endfunction

    // One clock: inputs are already driven; compare mid-cycle, then advance the model at the edge.
    task automatic tick();
        @(negedge clk_i);
        model_eval();
        compare_all();
        p_vid_done = e_vid_ack;
        p_cpu_done = e_cpu_ack | e_cpu_err;
        @(posedge clk_i);
        model_advance();
        #1;
    endtask

    task automatic idle_inputs();
        vid_cyc_i = 0; vid_adr_i = 0;
        cpu_cyc_i = 0; cpu_we_i = 0; cpu_sel_i = 0; cpu_adr_i = 0; cpu_dat_i = 0;
        mem_dat_i = 0; mem_ack_i = 0;
    endtask

    int rise, ackn, vgr, vack, cgr, errn, errc, own_after, vcnt;
    logic [31:0] dat_seen;

    initial begin
        idle_inputs();
        p_vid_done = 0; p_cpu_done = 0;
        rst_i = 1;
        #1;
        model_advance();
        model_eval();
        compare_all();
        check("reset_own", 32'(e_own), 32'd0);
        tick(); tick();
        rst_i = 0;
        tick();

        // CPU read at 0x40, memory acks 3 cycles after grant
        rise = -1; ackn = -1; dat_seen = 0;
        for (int n = 0; n < 8; n++) begin
            cpu_cyc_i = (n <= 4); cpu_we_i = 0; cpu_sel_i = 4'hF; cpu_adr_i = 32'h40;
            mem_ack_i = (n == 4); mem_dat_i = 32'hCAFE_0040;
            tick();
            if (e_mem_cyc && rise < 0) rise = n;
            if (e_cpu_ack) begin ackn = n; dat_seen = e_cpu_dat; end
        end
        check("cpu_rd_grant_cycle", 32'(rise), 32'd1);
        check("cpu_rd_ack_cycle", 32'(ackn), 32'd4);
        check("cpu_rd_data", dat_seen, 32'hCAFE_0040);
        idle_inputs();

        // Simultaneous requests: video first, CPU one dead cycle after video ack
        vgr = -1; vack = -1; cgr = -1;
        for (int n = 0; n < 8; n++) begin
            vid_cyc_i = (n <= 2); vid_adr_i = 32'h0000_1000;
            cpu_cyc_i = (n <= 5); cpu_adr_i = 32'h0000_2000; cpu_sel_i = 4'h3;
            mem_ack_i = (n == 2 || n == 5); mem_dat_i = 32'h1234_0000 + 32'(n);
            tick();
            if (e_own == 1 && vgr < 0) vgr = n;
            if (e_vid_ack && vack < 0) vack = n;
            if (e_own == 2 && cgr < 0) cgr = n;
        end
        check("both_vid_grant", 32'(vgr), 32'd1);
        check("both_vid_ack", 32'(vack), 32'd2);
        check("both_cpu_grant", 32'(cgr), 32'd4);
        idle_inputs();

        // Gapless video traffic with CPU waiting: starvation hands CPU the bus
        cgr = -1; vcnt = 0;
        for (int n = 0; n < 80; n++) begin
            vid_cyc_i = 1; vid_adr_i = 32'h8000_0000 + 32'(n);
            cpu_cyc_i = (cgr < 0 || n == cgr); cpu_adr_i = 32'h0000_0400;
            mem_ack_i = 1; mem_dat_i = $urandom;
            tick();
            if (e_own == 2 && cgr < 0) cgr = n;
            if (e_vid_ack && cgr < 0) vcnt++;
        end
        check("starve_cpu_grant", 32'(cgr), 32'd65);
        check("starve_vid_acks", 32'(vcnt), 32'd32);
        idle_inputs();
        tick();

        // CPU write with no memory ack: timeout error pulse
        errn = -1; errc = 0; own_after = -1;
        for (int n = 0; n < 300; n++) begin
            cpu_cyc_i = (errn < 0); cpu_we_i = 1; cpu_sel_i = 4'hC;
            cpu_adr_i = 32'h0000_0ABC; cpu_dat_i = 32'hDEAD_BEEF;
            mem_ack_i = 0;
            tick();
            if (e_cpu_err) begin errc++; if (errn < 0) errn = n; end
            if (errn >= 0 && n == errn + 1) own_after = e_own;
        end
        check("timeout_err_cycle", 32'(errn), 32'd256);
        check("timeout_err_count", 32'(errc), 32'd1);
        check("timeout_back_idle", 32'(own_after), 32'd0);
        idle_inputs();
        tick();

        // Reset in S_VID with an ack arriving: no ack, outputs drop at once
        vid_cyc_i = 1; vid_adr_i = 32'h0000_0777;
        tick();
        mem_ack_i = 1; mem_dat_i = 32'h5555_AAAA;
        rst_i = 1;
        #1;
        model_advance();
        model_eval();
        compare_all();
        check("rst_vid_ack_model", 32'(e_vid_ack), 32'd0);
        tick();
        rst_i = 0; mem_ack_i = 0;
        vgr = -1;
        for (int n = 0; n < 4; n++) begin
            mem_ack_i = (n == 1);
            vid_cyc_i = (n <= 1);
            tick();
            if (e_own == 1 && vgr < 0) vgr = n;
        end
        check("post_rst_grant", 32'(vgr), 32'd1);
        idle_inputs();
        tick();

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            if (vid_cyc_i && p_vid_done) begin
                if ($urandom % 2 == 0) vid_adr_i = $urandom;
                else vid_cyc_i = 0;
            end else if (!vid_cyc_i && $urandom % 3 == 0) begin
                vid_cyc_i = 1; vid_adr_i = $urandom;
            end else if (vid_cyc_i && $urandom % 97 == 0) begin
                vid_cyc_i = 0;
            end
            if (cpu_cyc_i && p_cpu_done) begin
                cpu_cyc_i = 0;
            end else if (!cpu_cyc_i && $urandom % 4 == 0) begin
                cpu_cyc_i = 1; cpu_we_i = 1'($urandom); cpu_sel_i = 4'($urandom);
                cpu_adr_i = $urandom; cpu_dat_i = $urandom;
            end else if (cpu_cyc_i && $urandom % 101 == 0) begin
                cpu_cyc_i = 0;
            end
            mem_ack_i = ($urandom % 4 == 0);
            mem_dat_i = $urandom;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
